// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - two-requester round-robin binary-to-BCD (double-dabble) converter
module bcd_conv_arbiter #(
   parameter int BIN_W      = 20,
   parameter int BCD_DIGITS = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req0,
   input  logic [BIN_W-1:0]          bin0,
   input  logic                      req1,
   input  logic [BIN_W-1:0]          bin1,
   output logic                      gnt0,
   output logic                      gnt1,
   output logic                      busy,
   output logic                      valid,
   output logic                      owner,
   output logic [4*BCD_DIGITS-1:0]   bcd,
   output logic                      ovf
);

   // one spare digit above the result so operands up to 2^20-1 never lose bits
   localparam int ACC_W = 4 * (BCD_DIGITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [BIN_W-1:0] opnd;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_adj;
   logic [ACC_W-1:0] acc_step;
   logic             acc_carry;
   logic [4:0]       cnt;
   logic             cur;
   logic             rr_pri;
   logic             accept;
   logic             sel;
   logic             last_iter;

   // arbitration: accept only in IDLE; on contention the round-robin pointer decides
   always_comb begin
      accept = 1'b0;
      sel    = 1'b0;
      if (state == IDLE) begin
         accept = req0 | req1;
         sel    = (req0 && req1) ? rr_pri : req1;
      end
   end

   // one double-dabble step: add 3 to every digit >= 5, then shift in the next operand bit
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < BCD_DIGITS + 1; d++) begin
         if (acc[4*d +: 4] >= 4'd5) begin
            acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
         end
      end
      // the bit leaving the top cannot be set for supported operand widths; it is kept
      // and folded into ovf so that nothing is dropped silently
      {acc_carry, acc_step} = {acc_adj, opnd[BIN_W-1]};
   end

   assign last_iter = (cnt == 5'(BIN_W - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and busy decode
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // datapath: operand capture, iteration, result registers and grant/valid pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         cur    <= 1'b0;
         rr_pri <= 1'b0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         valid  <= 1'b0;
         owner  <= 1'b0;
         bcd    <= '0;
         ovf    <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  opnd   <= sel ? bin1 : bin0;
                  acc    <= '0;
                  cnt    <= '0;
                  cur    <= sel;
                  gnt0   <= ~sel;
                  gnt1   <= sel;
                  rr_pri <= ~sel;
               end
            end
            SHIFT: begin
               acc  <= acc_step;
               opnd <= {opnd[BIN_W-2:0], 1'b0};
               cnt  <= cnt + 5'd1;
               if (last_iter) begin
                  bcd   <= acc_step[4*BCD_DIGITS-1:0];
                  ovf   <= (acc_step[ACC_W-1:4*BCD_DIGITS] != '0) | acc_carry;
                  owner <= cur;
                  valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - directed self-checking bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0;
   logic [19:0] bin0;
   logic        req1;
   logic [19:0] bin1;
   logic        gnt0;
   logic        gnt1;
   logic        busy;
   logic        valid;
   logic        owner;
   logic [23:0] bcd;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   bcd_conv_arbiter #(.BIN_W(20), .BCD_DIGITS(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .bin0  (bin0),
      .req1  (req1),
      .bin1  (bin1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .busy  (busy),
      .valid (valid),
      .owner (owner),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // one isolated conversion; operand is scrambled right after the grant
   task automatic convert(input int r, input logic [19:0] b,
                          output logic g0, output logic g1, output int lat,
                          output logic [23:0] rb, output logic ro, output logic row);
      @(negedge clk);
      if (r == 0) begin req0 = 1'b1; bin0 = b; end
      else        begin req1 = 1'b1; bin1 = b; end
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      req0 = 1'b0;
      req1 = 1'b0;
      bin0 = ~b;
      bin1 = ~b;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (valid) begin lat = i; break; end
      end
      rb  = bcd;
      ro  = ovf;
      row = owner;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gnt0, gnt1, busy, valid, owner, ovf, bcd} !== 30'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", {gnt0, gnt1, busy, valid, owner, ovf, bcd});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic g0, g1, ro, row;
      logic [23:0] rb;
      int lat;
      convert(0, 20'd123456, g0, g1, lat, rb, ro, row);
      total++; if ({g0, g1} !== 2'b10) begin bad++; $display("FAIL single_gnt: got %b want 10", {g0, g1}); end
      total++; if (lat !== 20) begin bad++; $display("FAIL single_latency: got %0d want 20", lat); end
      total++; if (rb !== 24'h123456) begin bad++; $display("FAIL single_bcd: got %h want 123456", rb); end
      total++; if (ro !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", ro); end
      total++; if (row !== 1'b0) begin bad++; $display("FAIL single_owner: got %b want 0", row); end
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse: got %b want 0", valid); end
      total++; if (bcd !== 24'h123456) begin bad++; $display("FAIL single_bcd_hold: got %h want 123456", bcd); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b want 0", busy); end
   endtask

   task automatic test_boundaries();
      logic [19:0] vin [3];
      logic [23:0] vexp [3];
      logic        oexp [3];
      logic g0, g1, ro, row;
      logic [23:0] rb;
      int lat;
      vin[0] = 20'd0;      vexp[0] = 24'h000000; oexp[0] = 1'b0;
      vin[1] = 20'd999999; vexp[1] = 24'h999999; oexp[1] = 1'b0;
      vin[2] = 20'hFFFFF;  vexp[2] = 24'h048575; oexp[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         convert(1, vin[k], g0, g1, lat, rb, ro, row);
         total++; if ({g0, g1} !== 2'b01) begin bad++; $display("FAIL bound%0d_gnt: got %b want 01", k, {g0, g1}); end
         total++; if (lat !== 20) begin bad++; $display("FAIL bound%0d_latency: got %0d want 20", k, lat); end
         total++; if (rb !== vexp[k]) begin bad++; $display("FAIL bound%0d_bcd: got %h want %h", k, rb, vexp[k]); end
         total++; if (ro !== oexp[k]) begin bad++; $display("FAIL bound%0d_ovf: got %b want %b", k, ro, oexp[k]); end
         total++; if (row !== 1'b1) begin bad++; $display("FAIL bound%0d_owner: got %b want 1", k, row); end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      req0 = 1'b1; bin0 = 20'd5;
      @(negedge clk);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL areset_busy_before: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gnt0, gnt1, busy, valid, owner, ovf, bcd} !== 30'd0) begin
         bad++;
         $display("FAIL areset_outputs: got %h want 0", {gnt0, gnt1, busy, valid, owner, ovf, bcd});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_abort();
      logic g0, g1, ro, row;
      logic [23:0] rb;
      int lat;
      int nvalid;
      @(negedge clk);
      req1 = 1'b1; bin1 = 20'd777;
      @(negedge clk);
      total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL abort_gnt: got %b want 1", gnt1); end
      req1 = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nvalid = 0;
      repeat (30) begin
         @(negedge clk);
         if (valid) nvalid++;
      end
      total++; if (nvalid !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d want 0", nvalid); end
      convert(1, 20'd42, g0, g1, lat, rb, ro, row);
      total++; if ({g0, g1} !== 2'b01) begin bad++; $display("FAIL abort_next_gnt: got %b want 01", {g0, g1}); end
      total++; if (lat !== 20) begin bad++; $display("FAIL abort_next_latency: got %0d want 20", lat); end
      total++; if (rb !== 24'h000042) begin bad++; $display("FAIL abort_next_bcd: got %h want 000042", rb); end
   endtask

   task automatic test_contention();
      logic [19:0] vals [4];
      logic [23:0] vexp [4];
      logic        oexp [4];
      int w;
      int lat;
      vals[0] = 20'd111111;  vexp[0] = 24'h111111; oexp[0] = 1'b0;
      vals[1] = 20'd222222;  vexp[1] = 24'h222222; oexp[1] = 1'b0;
      vals[2] = 20'd654321;  vexp[2] = 24'h654321; oexp[2] = 1'b0;
      vals[3] = 20'd1000000; vexp[3] = 24'h000000; oexp[3] = 1'b1;
      @(negedge clk);
      bin0 = vals[0]; bin1 = vals[1];
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (w < 30) begin
            @(negedge clk);
            w++;
            if (gnt0 || gnt1) break;
         end
         total++;
         if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL cont%0d_gnt: got %b want %b", k, {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (k > 0) begin
            total++; if (w !== 2) begin bad++; $display("FAIL cont%0d_gap: got %0d want 2", k, w); end
         end
         if (k % 2 == 0) bin0 = 20'h5A5A5;
         else            bin1 = 20'h5A5A5;
         lat = -1;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 7) begin bin0 = 20'hA5A5A; bin1 = 20'hA5A5A; end
            if (valid) begin lat = i; break; end
         end
         total++; if (lat !== 20) begin bad++; $display("FAIL cont%0d_latency: got %0d want 20", k, lat); end
         total++; if (bcd !== vexp[k]) begin bad++; $display("FAIL cont%0d_bcd: got %h want %h", k, bcd, vexp[k]); end
         total++; if (ovf !== oexp[k]) begin bad++; $display("FAIL cont%0d_ovf: got %b want %b", k, ovf, oexp[k]); end
         total++; if (owner !== 1'(k % 2)) begin bad++; $display("FAIL cont%0d_owner: got %b want %0d", k, owner, k % 2); end
         if (k < 3) begin
            if ((k + 1) % 2 == 0) bin0 = vals[k + 1];
            else                  bin1 = vals[k + 1];
         end else begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
   endtask

   task automatic test_busy_window();
      int early;
      int lat;
      @(negedge clk);
      req1 = 1'b1; bin1 = 20'd7;
      @(negedge clk);
      total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL bw_gnt1: got %b want 1", gnt1); end
      req1 = 1'b0; bin1 = '0;
      repeat (5) @(negedge clk);
      req0 = 1'b1; bin0 = 20'd99;
      early = 0;
      lat = -1;
      for (int i = 6; i <= 40; i++) begin
         @(negedge clk);
         if (gnt0) early++;
         if (valid) begin lat = i; break; end
      end
      total++; if (early !== 0) begin bad++; $display("FAIL bw_no_early_gnt: got %0d want 0", early); end
      total++; if (lat !== 20) begin bad++; $display("FAIL bw_latency: got %0d want 20", lat); end
      total++; if (bcd !== 24'h000007) begin bad++; $display("FAIL bw_bcd: got %h want 000007", bcd); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bw_busy_at_valid: got %b want 1", busy); end
      @(negedge clk);
      total++; if ({gnt0, busy} !== 2'b00) begin bad++; $display("FAIL bw_idle_cycle: got %b want 00", {gnt0, busy}); end
      @(negedge clk);
      total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL bw_gnt0_e22: got %b want 10", {gnt0, gnt1}); end
      req0 = 1'b0; bin0 = 20'hFFFFF;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (valid) begin lat = i; break; end
      end
      total++; if (lat !== 20) begin bad++; $display("FAIL bw_second_latency: got %0d want 20", lat); end
      total++; if (bcd !== 24'h000099) begin bad++; $display("FAIL bw_second_bcd: got %h want 000099", bcd); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL bw_second_owner: got %b want 0", owner); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_async_reset();
      test_abort();
      test_contention();
      test_busy_window();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
